control_unit: RTL and testbench

- FSM controller that drives the processor datapath's control inputs: data-memory address/write, register-file read/write addresses and enables, write-back mux select, ALU function.
- Owns the program counter (PC) and instruction register (IR).
- Fetches 16-bit instructions from a synchronous instruction ROM (1-cycle registered read), decodes them and sequences the datapath.
- Sits beside the datapath in the processor top level.

---
 rtl/control_unit.sv | 164 ++++++++++++++++
 tb/tb_control_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit
// Multi-cycle FSM controller for a small load/store processor. It owns the
// program counter and instruction register. It fetches 16-bit instructions
// from a synchronous instruction ROM, decodes them and drives the datapath
// control inputs for one instruction at a time.
//
// Ports:
//   Clock, Reset     rising-edge clock, synchronous active-low reset
//   PC_addr          instruction-ROM address (PC register)
//   I_data           instruction-ROM registered output
//   D_addr, D_wr     data-memory address / write enable
//   RF_s             write-back select: 1 = memory data, 0 = ALU result
//   RF_W_addr/_wr    register-file write port
//   RF_Ra_addr/_rd   register-file read port A
//   RF_Rb_addr/_rd   register-file read port B
//   Alu_s0           ALU function select
//   IR_out           IR contents (debug)
//   State_out        state encoding (debug)
//   Halted           high while in HALT
module control_unit #(
  parameter int          PC_WIDTH = 7,
  parameter logic [2:0]  ALU_ADD  = 3'b001,
  parameter logic [2:0]  ALU_SUB  = 3'b010
) (
  input  logic                Clock,
  input  logic                Reset,
  output logic [PC_WIDTH-1:0] PC_addr,
  input  logic [15:0]         I_data,
  output logic [7:0]          D_addr,
  output logic                D_wr,
  output logic                RF_s,
  output logic [3:0]          RF_W_addr,
  output logic                RF_W_wr,
  output logic [3:0]          RF_Ra_addr,
  output logic                RF_Ra_rd,
  output logic [3:0]          RF_Rb_addr,
  output logic                RF_Rb_rd,
  output logic [2:0]          Alu_s0,
  output logic [15:0]         IR_out,
  output logic [3:0]          State_out,
  output logic                Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;
  logic [3:0]          opcode;

  assign opcode = ir[15:12];

  // PC and IR only move in FETCH; the DECODE cycle that always follows gives
  // the ROM its one cycle of read latency before the next FETCH.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        ir <= I_data;
        pc <= pc + PC_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt = S_INIT;
    case (state)
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_STORE: state_nxt = S_STORE;
          OP_LOAD:  state_nxt = S_LOAD_A;
          OP_ADD:   state_nxt = S_ADD;
          OP_SUB:   state_nxt = S_SUB;
          OP_HALT:  state_nxt = S_HALT;
          OP_NOOP:  state_nxt = S_NOOP;
          default:  state_nxt = S_NOOP;  // unassigned opcodes run as NOOP
        endcase
      end
      S_NOOP:   state_nxt = S_FETCH;
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_FETCH;
      S_STORE:  state_nxt = S_FETCH;
      S_ADD:    state_nxt = S_FETCH;
      S_SUB:    state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_wr    = 1'b0;
    RF_Ra_addr = '0;
    RF_Ra_rd   = 1'b0;
    RF_Rb_addr = '0;
    RF_Rb_rd   = 1'b0;
    Alu_s0     = '0;
    Halted     = 1'b0;
    case (state)
      S_STORE: begin
        D_addr     = ir[7:0];
        D_wr       = 1'b1;
        RF_Ra_addr = ir[11:8];
        RF_Ra_rd   = 1'b1;
      end
      // LOAD_A only presents the address so the data memory can return the
      // word; the register write happens in LOAD_B.
      S_LOAD_A: begin
        D_addr = ir[11:4];
        RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        D_addr    = ir[11:4];
        RF_s      = 1'b1;
        RF_W_addr = ir[3:0];
        RF_W_wr   = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir[11:8];
        RF_Ra_rd   = 1'b1;
        RF_Rb_addr = ir[7:4];
        RF_Rb_rd   = 1'b1;
        RF_W_addr  = ir[3:0];
        RF_W_wr    = 1'b1;
        Alu_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

  assign PC_addr   = pc;
  assign IR_out    = ir;
  assign State_out = state;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  localparam int PCW = 7;

  logic           Clock;
  logic           Reset;
  logic [PCW-1:0] PC_addr;
  logic [15:0]    I_data;
  logic [7:0]     D_addr;
  logic           D_wr;
  logic           RF_s;
  logic [3:0]     RF_W_addr;
  logic           RF_W_wr;
  logic [3:0]     RF_Ra_addr;
  logic           RF_Ra_rd;
  logic [3:0]     RF_Rb_addr;
  logic           RF_Rb_rd;
  logic [2:0]     Alu_s0;
  logic [15:0]    IR_out;
  logic [3:0]     State_out;
  logic           Halted;

  control_unit #(.PC_WIDTH(PCW)) dut (
    .Clock(Clock), .Reset(Reset), .PC_addr(PC_addr), .I_data(I_data),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
    .RF_Ra_addr(RF_Ra_addr), .RF_Ra_rd(RF_Ra_rd),
    .RF_Rb_addr(RF_Rb_addr), .RF_Rb_rd(RF_Rb_rd),
    .Alu_s0(Alu_s0), .IR_out(IR_out), .State_out(State_out), .Halted(Halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction ROM with registered read, plus a tiny datapath driven by the
  // DUT's control outputs so instruction effects can be observed.
  logic [15:0] rom  [0:127];
  logic [7:0]  dmem [0:255];
  logic [7:0]  rf   [0:15];
  logic [7:0]  dq;
  logic [7:0]  alu_y;

  always @(posedge Clock) I_data <= rom[PC_addr];

  always_comb begin
    alu_y = 8'h00;
    if (Alu_s0 == 3'b001) alu_y = rf[RF_Ra_addr] + rf[RF_Rb_addr];
    else if (Alu_s0 == 3'b010) alu_y = rf[RF_Ra_addr] - rf[RF_Rb_addr];
  end

  always @(posedge Clock) begin
    dq <= dmem[D_addr];
    if (D_wr) dmem[D_addr] <= rf[RF_Ra_addr];
    if (RF_W_wr) rf[RF_W_addr] <= RF_s ? dq : alu_y;
  end

  // Instruction-level reference model: where in its instruction the machine
  // is (fetch / decode / first or second execute cycle / halted).
  localparam int P_INIT = 0, P_FETCH = 1, P_DECODE = 2, P_EX1 = 3, P_EX2 = 4, P_HALT = 5;
  int          m_phase;
  logic [6:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_ok = 1'b0;

  always @(posedge Clock) begin
    if (Reset === 1'b0) begin
      m_ok = 1'b1; m_phase = P_INIT; m_pc = 7'd0; m_ir = 16'h0000;
    end else if (m_ok) begin
      case (m_phase)
        P_INIT:   m_phase = P_FETCH;
        P_FETCH:  begin m_ir = rom[m_pc]; m_pc = m_pc + 7'd1; m_phase = P_DECODE; end
        P_DECODE: m_phase = (m_ir[15:12] == 4'h5) ? P_HALT : P_EX1;
        P_EX1:    m_phase = (m_ir[15:12] == 4'h2) ? P_EX2 : P_FETCH;
        P_EX2:    m_phase = P_FETCH;
        default:  m_phase = P_HALT;
      endcase
    end
  end

  function automatic logic [3:0] exp_state(int ph, logic [15:0] ir);
    case (ph)
      P_INIT:   return 4'd0;
      P_FETCH:  return 4'd1;
      P_DECODE: return 4'd2;
      P_EX2:    return 4'd5;
      P_HALT:   return 4'd9;
      default:
        case (ir[15:12])
          4'h1:    return 4'd6;
          4'h2:    return 4'd4;
          4'h3:    return 4'd7;
          4'h4:    return 4'd8;
          default: return 4'd3;
        endcase
    endcase
  endfunction

  // {D_addr, D_wr, RF_s, W_addr, W_wr, Ra_addr, Ra_rd, Rb_addr, Rb_rd, Alu}
  function automatic logic [27:0] exp_ctrl(int ph, logic [15:0] ir);
    logic [7:0] da; logic dw, s, ww, rar, rbr; logic [3:0] w, ra, rb; logic [2:0] alu;
    da = 0; dw = 0; s = 0; ww = 0; rar = 0; rbr = 0; w = 0; ra = 0; rb = 0; alu = 0;
    if (ph == P_EX1) begin
      case (ir[15:12])
        4'h1: begin da = ir[7:0]; dw = 1; ra = ir[11:8]; rar = 1; end
        4'h2: begin da = ir[11:4]; s = 1; end
        4'h3, 4'h4: begin
          ra = ir[11:8]; rar = 1; rb = ir[7:4]; rbr = 1; w = ir[3:0]; ww = 1;
          alu = (ir[15:12] == 4'h3) ? 3'b001 : 3'b010;
        end
        default: ;
      endcase
    end else if (ph == P_EX2) begin
      da = ir[11:4]; s = 1; w = ir[3:0]; ww = 1;
    end
    return {da, dw, s, w, ww, ra, rar, rb, rbr, alu};
  endfunction

  logic [27:0] ctrl;
  assign ctrl = {D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr, RF_Ra_addr, RF_Ra_rd,
                 RF_Rb_addr, RF_Rb_rd, Alu_s0};

  always @(negedge Clock) begin
    if (m_ok) begin
      chk("m_state", 32'(State_out), 32'(exp_state(m_phase, m_ir)));
      chk("m_pc",    32'(PC_addr),   32'(m_pc));
      chk("m_ir",    32'(IR_out),    32'(m_ir));
      chk("m_ctrl",  32'(ctrl),      32'(exp_ctrl(m_phase, m_ir)));
      chk("m_halt",  32'(Halted),    32'(m_phase == P_HALT));
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Expected state after each clock from reset release through HALT.
  int seq [0:19] = '{0, 1, 2, 4, 5, 1, 2, 7, 1, 2, 8, 1, 2, 6, 1, 2, 3, 1, 2, 9};

  initial begin
    bit found;
    Reset = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    rom[0] = 16'h2A35; rom[1] = 16'h3123; rom[2] = 16'h4123;
    rom[3] = 16'h152B; rom[4] = 16'hF123; rom[5] = 16'h5000;
    rf[1] = 8'd7; rf[2] = 8'd5; dmem[8'hA3] = 8'h5C;

    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      chk($sformatf("seq%0d_state", i), 32'(State_out), 32'(seq[i]));
      case (i)
        0: begin chk("init_pc", 32'(PC_addr), 0); chk("init_ir", 32'(IR_out), 0);
                 chk("init_ctrl", 32'(ctrl), 0); end
        1: chk("fetch_pc", 32'(PC_addr), 0);
        2: begin chk("decode_pc", 32'(PC_addr), 1); chk("decode_ir", 32'(IR_out), 32'h2A35); end
        3: begin chk("loada_daddr", 32'(D_addr), 32'hA3); chk("loada_rfs", 32'(RF_s), 1);
                 chk("loada_wwr", 32'(RF_W_wr), 0); end
        4: begin chk("loadb_waddr", 32'(RF_W_addr), 5); chk("loadb_wwr", 32'(RF_W_wr), 1); end
        7: begin chk("add_ra", 32'(RF_Ra_addr), 1); chk("add_rb", 32'(RF_Rb_addr), 2);
                 chk("add_w", 32'(RF_W_addr), 3); chk("add_alu", 32'(Alu_s0), 1);
                 chk("add_rfs", 32'(RF_s), 0);
                 chk("add_en", 32'({RF_Ra_rd, RF_Rb_rd, RF_W_wr}), 7); end
        8: begin chk("after_add_en", 32'({RF_Ra_rd, RF_Rb_rd, RF_W_wr}), 0);
                 chk("r3_sum", 32'(rf[3]), 12); end
        10: chk("sub_alu", 32'(Alu_s0), 2);
        13: begin chk("store_daddr", 32'(D_addr), 32'h2B); chk("store_ra", 32'(RF_Ra_addr), 5);
                  chk("store_dwr", 32'(D_wr), 1); chk("store_wwr", 32'(RF_W_wr), 0); end
        16: chk("noop_writes", 32'({D_wr, RF_W_wr}), 0);
        default: ;
      endcase
    end
    chk("r3_diff", 32'(rf[3]), 2);
    chk("r5_loaded", 32'(rf[5]), 32'h5C);
    chk("dmem_2b", 32'(dmem[8'h2B]), 32'h5C);

    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_flag", 32'(Halted), 1);
      chk("halt_pc", 32'(PC_addr), 6);
      chk("halt_ctrl", 32'(ctrl), 0);
    end

    // Reset in the middle of a LOAD
    Reset = 1'b0; step(); Reset = 1'b1;
    repeat (3) step();
    chk("mid_loada", 32'(State_out), 4);
    chk("mid_wwr", 32'(RF_W_wr), 0);
    Reset = 1'b0; step();
    chk("mid_state", 32'(State_out), 0);
    chk("mid_pc", 32'(PC_addr), 0);
    chk("mid_ir", 32'(IR_out), 0);
    chk("mid_wwr2", 32'(RF_W_wr), 0);
    Reset = 1'b1;

    // PC wrap: run NOOPs until PC=127 is fetched
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    Reset = 1'b0; step(); Reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (PC_addr == 7'd127 && State_out == 4'd1) found = 1'b1;
    end
    chk("wrap_reached", 32'(found), 1);
    step();
    chk("wrap_pc", 32'(PC_addr), 0);
    chk("wrap_state", 32'(State_out), 2);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
